// File: rtl/async_fifo_wptr_full_ble_if.sv
// Write-side bus of the BLE PHY async FIFO pointer controller.
// master: the write-domain client / synchroniser side; slave: the controller.
interface async_fifo_wptr_full_ble_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  W_inc;
  logic [ADDR_WIDTH:0]   Wq2_rptr;
  logic                  W_clr_ovf;
  logic                  W_en;
  logic [ADDR_WIDTH-1:0] W_addr;
  logic [ADDR_WIDTH:0]   W_ptr;
  logic                  W_full;
  logic                  W_afull;
  logic [ADDR_WIDTH:0]   W_level;
  logic                  W_ovf;

  modport master (
    output W_inc, Wq2_rptr, W_clr_ovf,
    input  W_en, W_addr, W_ptr, W_full, W_afull, W_level, W_ovf
  );

  modport slave (
    input  W_inc, Wq2_rptr, W_clr_ovf,
    output W_en, W_addr, W_ptr, W_full, W_afull, W_level, W_ovf
  );
endinterface

// File: rtl/async_fifo_wptr_full_ble.sv
// Write-side pointer and full/level controller for the BLE PHY async FIFO.
// Everything here runs on W_CLK; the read pointer arrives already synchronised
// as Gray code, so full/level are pessimistic by the synchroniser latency.
module async_fifo_wptr_full_ble #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input logic W_CLK,
  input logic W_rst,
  async_fifo_wptr_full_ble_if.slave bus
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

  logic [PW-1:0] bin;
  logic [PW-1:0] gray_q;
  logic          full_q;
  logic          afull_q;
  logic [PW-1:0] level_q;
  logic          ovf_q;

  logic          en;
  logic [PW-1:0] bnext;
  logic [PW-1:0] gnext;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_pattern;

  // A write is only accepted when not full; reset blocks any strobe to memory.
  assign en = bus.W_inc & ~full_q & ~W_rst;

  assign bnext = bin + PW'(en);
  assign gnext = (bnext >> 1) ^ bnext;

  // Gray-to-binary of the synchronised read pointer: bit i is the XOR of all
  // Gray bits from the MSB down to i.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(bus.Wq2_rptr >> i);
    end
  end

  assign level_next = bnext - rbin;

  // Full when the next write pointer equals the read pointer with the top two
  // Gray bits inverted, i.e. exactly one lap ahead.
  assign full_pattern = {~bus.Wq2_rptr[PW-1:PW-2], bus.Wq2_rptr[PW-3:0]};

  // Pointer, flags and level all register together so they stay coherent.
  always_ff @(posedge W_CLK or posedge W_rst) begin
    if (W_rst) begin
      bin     <= '0;
      gray_q  <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
    end else begin
      bin     <= bnext;
      gray_q  <= gnext;
      full_q  <= (gnext == full_pattern);
      afull_q <= (level_next >= AFULL_T);
      level_q <= level_next;
    end
  end

  // Sticky overflow: a dropped write sets it, and a set beats a same-cycle clear.
  always_ff @(posedge W_CLK or posedge W_rst) begin
    if (W_rst) begin
      ovf_q <= 1'b0;
    end else if (bus.W_inc & full_q) begin
      ovf_q <= 1'b1;
    end else if (bus.W_clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.W_en    = en;
  assign bus.W_addr  = bin[ADDR_WIDTH-1:0];
  assign bus.W_ptr   = gray_q;
  assign bus.W_full  = full_q;
  assign bus.W_afull = afull_q;
  assign bus.W_level = level_q;
  assign bus.W_ovf   = ovf_q;

endmodule

// File: tb/tb_async_fifo_wptr_full_ble.sv
// Bench for the async FIFO write-pointer controller. The reference keeps plain
// integer counts of accepted writes and of the read position it publishes, and
// derives pointer, level and flags from those counts.
module tb_async_fifo_wptr_full_ble;

  logic W_CLK;
  logic W_rst;

  async_fifo_wptr_full_ble_if #(.ADDR_WIDTH(4)) bus ();

  async_fifo_wptr_full_ble #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
    .W_CLK (W_CLK),
    .W_rst (W_rst),
    .bus   (bus)
  );

  initial begin
    W_CLK = 1'b0;
    forever #5 W_CLK = ~W_CLK;
  end

  int checks = 0;
  int errors = 0;

  // Reference state
  int wr_count = 0;
  int rd_count = 0;
  bit m_full   = 0;
  bit m_afull  = 0;
  bit m_ovf    = 0;
  int m_level  = 0;
  logic [4:0] prev_ptr = '0;

  function automatic logic [4:0] to_gray(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    wr_count = 0;
    rd_count = 0;
    m_full   = 0;
    m_afull  = 0;
    m_ovf    = 0;
    m_level  = 0;
    prev_ptr = '0;
  endtask

  task automatic drive(input logic inc, input logic clr);
    bus.W_inc     = inc;
    bus.W_clr_ovf = clr;
    bus.Wq2_rptr  = to_gray(rd_count);
    #1;
  endtask

  task automatic tick();
    bit acc;
    bit ovf_n;
    acc   = bus.W_inc && !m_full;
    ovf_n = (bus.W_inc && m_full) ? 1'b1 : (bus.W_clr_ovf ? 1'b0 : m_ovf);
    @(posedge W_CLK);
    if (acc) wr_count++;
    m_level = wr_count - rd_count;
    m_full  = (m_level == 16);
    m_afull = (m_level >= 12);
    m_ovf   = ovf_n;
    #1;
  endtask

  task automatic step(input logic inc, input logic clr);
    drive(inc, clr);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ptr"},   32'(bus.W_ptr),   32'd0);
    chk({tag, "_addr"},  32'(bus.W_addr),  32'd0);
    chk({tag, "_full"},  32'(bus.W_full),  32'd0);
    chk({tag, "_afull"}, 32'(bus.W_afull), 32'd0);
    chk({tag, "_level"}, 32'(bus.W_level), 32'd0);
    chk({tag, "_ovf"},   32'(bus.W_ovf),   32'd0);
    chk({tag, "_en"},    32'(bus.W_en),    32'd0);
  endtask

  // Reset asynchronously with a write pending, away from any clock edge.
  task automatic do_reset();
    #2;
    bus.W_inc = 1'b1;
    W_rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    model_clear();
    bus.W_inc     = 1'b0;
    bus.W_clr_ovf = 1'b0;
    bus.Wq2_rptr  = '0;
    #2;
    W_rst = 1'b0;
    @(posedge W_CLK);
    #1;
  endtask

  // Per-cycle comparison against the reference.
  always @(negedge W_CLK) begin
    if (!W_rst) begin
      chk("cyc_ptr",   32'(bus.W_ptr),   32'(to_gray(wr_count)));
      chk("cyc_addr",  32'(bus.W_addr),  32'(wr_count % 16));
      chk("cyc_level", 32'(bus.W_level), 32'(m_level));
      chk("cyc_full",  32'(bus.W_full),  32'(m_full));
      chk("cyc_afull", 32'(bus.W_afull), 32'(m_afull));
      chk("cyc_ovf",   32'(bus.W_ovf),   32'(m_ovf));
      chk("cyc_en",    32'(bus.W_en),    32'(bus.W_inc && !m_full));
      chk("cyc_gray_step", 32'($countones(bus.W_ptr ^ prev_ptr) <= 1), 32'd1);
      prev_ptr = bus.W_ptr;
    end
  end

  initial begin
    W_rst         = 1'b1;
    bus.W_inc     = 1'b0;
    bus.W_clr_ovf = 1'b0;
    bus.Wq2_rptr  = '0;
    model_clear();
    #1;
    check_all_zero("rst_init");
    #12;
    W_rst = 1'b0;
    @(posedge W_CLK);
    #1;

    // Some writes, then reset in the middle of the burst.
    repeat (3) step(1'b1, 1'b0);
    chk("pre_rst_ptr", 32'(bus.W_ptr), 32'b00010);
    do_reset();

    // First write after reset.
    drive(1'b1, 1'b0);
    chk("first_addr", 32'(bus.W_addr), 32'd0);
    chk("first_en",   32'(bus.W_en),   32'd1);
    tick();
    chk("first_ptr",  32'(bus.W_ptr),  32'b00001);

    // Fill from empty with 16 writes.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0);
      if (i == 11) chk("afull_at_11", 32'(bus.W_afull), 32'd0);
      if (i == 12) chk("afull_at_12", 32'(bus.W_afull), 32'd1);
      if (i == 15) chk("full_at_15",  32'(bus.W_full),  32'd0);
    end
    chk("fill_full",  32'(bus.W_full),  32'd1);
    chk("fill_level", 32'(bus.W_level), 32'd16);
    chk("fill_ptr",   32'(bus.W_ptr),   32'b11000);

    // Overflow at full.
    drive(1'b1, 1'b0);
    chk("ovf_en", 32'(bus.W_en), 32'd0);
    tick();
    step(1'b1, 1'b0);
    chk("ovf_ptr", 32'(bus.W_ptr), 32'b11000);
    chk("ovf_set", 32'(bus.W_ovf), 32'd1);
    step(1'b1, 1'b1);
    chk("ovf_set_wins", 32'(bus.W_ovf), 32'd1);
    step(1'b0, 1'b1);
    chk("ovf_clr", 32'(bus.W_ovf), 32'd0);

    // Read pointer advances by one: full releases.
    rd_count = 1;
    step(1'b0, 1'b0);
    chk("drain_full",  32'(bus.W_full),  32'd0);
    chk("drain_level", 32'(bus.W_level), 32'd15);
    drive(1'b1, 1'b0);
    chk("drain_addr", 32'(bus.W_addr), 32'd0);
    chk("drain_en",   32'(bus.W_en),   32'd1);
    tick();
    chk("refill_full", 32'(bus.W_full), 32'd1);

    // Stream 40 writes with the read pointer two behind: crosses 31->0.
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("wrap_pre_level", 32'(bus.W_level), 32'd2);
    for (int i = 0; i < 40; i++) begin
      rd_count = wr_count - 1;
      step(1'b1, 1'b0);
      chk("wrap_level", 32'(bus.W_level), 32'd2);
      chk("wrap_full",  32'(bus.W_full),  32'd0);
    end
    chk("wrap_ptr", 32'(bus.W_ptr), 32'(5'b11111 & (5'd10 ^ 5'd5)));

    // Write and read advance together at level 8.
    do_reset();
    repeat (8) step(1'b1, 1'b0);
    chk("sim_level_pre", 32'(bus.W_level), 32'd8);
    chk("sim_addr_pre",  32'(bus.W_addr),  32'd8);
    rd_count = 1;
    step(1'b1, 1'b0);
    chk("sim_level", 32'(bus.W_level), 32'd8);
    chk("sim_addr",  32'(bus.W_addr),  32'd9);

    step(1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_wptr_full_ble.md
Name: async_fifo_wptr_full_ble

Overview:
Write-side pointer and full-flag controller for the BLE PHY asynchronous FIFO.
- Accepts write requests and produces the memory write enable and address.
- Publishes a registered Gray-coded write pointer for synchronisation into the read domain.
- Compares its own pointer against the already-synchronised Gray read pointer to derive full, almost-full, fill level and a sticky overflow flag.
- Runs entirely in the write clock domain.

Parameters:
ADDR_WIDTH, 4, FIFO address width; depth = 2^ADDR_WIDTH (16); pointers are ADDR_WIDTH+1 bits.
AFULL_THRESH, 12, level at or above which W_afull asserts; legal range 1..2^ADDR_WIDTH.

Ports:
W_CLK  input  1  write-domain clock, rising edge.
W_rst  input  1  asynchronous, active-high reset.
W_inc  input  1  write request for the current cycle.
Wq2_rptr  input  ADDR_WIDTH+1  Gray read pointer, already double-flop synchronised into W_CLK.
W_clr_ovf  input  1  clears the sticky overflow flag.
W_en  output  1  memory write strobe (combinational).
W_addr  output  ADDR_WIDTH  memory write address.
W_ptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchroniser.
W_full  output  1  FIFO full (registered).
W_afull  output  1  level >= AFULL_THRESH (registered).
W_level  output  ADDR_WIDTH+1  write-side fill estimate, 0..2^ADDR_WIDTH (registered).
W_ovf  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (W_rst high, async): binary pointer, W_ptr, W_full, W_afull, W_level and W_ovf all clear to 0. Reset has priority over every other input, including mid-burst; no partial update survives.
- Accept: W_en = W_inc & ~W_full. Only an accepted write advances the pointer.
- W_addr = binary pointer [ADDR_WIDTH-1:0]. Valid in the same cycle as W_en; memory captures on that W_CLK edge.
- Pointer update:
  - bnext = bin + W_en, modulo 2^(ADDR_WIDTH+1).
  - gnext = (bnext >> 1) ^ bnext.
  - bin and W_ptr load bnext and gnext on each edge.
  - W_ptr changes at most one bit per cycle; it is never driven from combinational logic.
- Full:
  - W_full register loads (gnext == {~Wq2_rptr[MSB:MSB-1], Wq2_rptr[MSB-2:0]}).
  - Asserts in the same edge as the write that fills the FIFO, so no extra write can slip through.
  - Deasserts only after the read pointer advance has been synchronised (pessimistic by sync latency).
- Level:
  - rbin = Gray-to-binary of Wq2_rptr (XOR prefix from MSB).
  - W_level register loads (bnext - rbin) modulo 2^(ADDR_WIDTH+1); result is 0..16 for the default parameters.
  - W_afull register loads (level_next >= AFULL_THRESH).
  - W_full and W_level==16 are always coincident.
- Wrap-around: the pointer rolls 31->0 (default); the MSB toggle distinguishes full from empty. Level and full must stay correct across the wrap.
- Overflow:
  - W_inc while W_full sets W_ovf on the next edge; the write is dropped and the pointer is unchanged.
  - W_clr_ovf clears W_ovf.
  - Set and clear in the same cycle: set wins, W_ovf stays 1.
- Simultaneous write and read-pointer advance: both are reflected in the same level_next computation, so W_level remains unchanged.

Test Plan:
- Reset check: assert W_rst mid-sim with W_inc=1 -> all outputs 0 immediately, without waiting for a W_CLK edge. After release, the first write gives W_addr=0 and W_ptr=5'b00001 next cycle.
- Fill: Wq2_rptr=0, 16 consecutive W_inc.
  - W_en high for writes 1-16.
  - W_afull=1 after write 12.
  - W_full=1 and W_level=16 after write 16; W_ptr=5'b11000 (Gray of 16).
- Overflow: at full, W_inc=1 for 2 cycles -> W_en=0, W_ptr unchanged, W_ovf=1. Then W_clr_ovf=1 with W_inc=1 -> W_ovf stays 1. Then W_clr_ovf=1 with W_inc=0 -> W_ovf=0.
- Drain release: from full, drive Wq2_rptr=Gray(1)=5'b00001 -> next edge W_full=0, W_level=15. Next W_inc is accepted with W_addr=0.
- Wrap: stream 40 writes with Wq2_rptr tracking bin-2 (Gray) -> W_level constant 2. At every edge the W_ptr Hamming distance from its previous value is <=1. The pointer passes 31->0 without W_full asserting.
- Simultaneous: level 8, W_inc=1 while Wq2_rptr advances by one -> W_level stays 8, W_addr increments.
